// File: rtl/bitpack_ssm.sv
// Substream bit packer: concatenates MSB-aligned variable-length codewords into 128-bit MSB-first words.
// Optional feature macro: BITPACK_SSM_STATS_EN adds a 32-bit accepted-bit counter port (bit_count).
module bitpack_ssm #(
    parameter int ssm_idx = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_vld,
    output logic         blk_rdy,
    input  logic [127:0] blk_bits,
    input  logic [7:0]   blk_size,
    input  logic         flush,
    output logic         word_vld,
    input  logic         word_rdy,
    output logic [127:0] word_data,
    output logic         word_last,
`ifdef BITPACK_SSM_STATS_EN
    output logic [31:0]  bit_count,
`endif
    output logic         flush_done
);

    typedef enum logic {
        ACTIVE = 1'b0,
        FLUSH  = 1'b1
    } state_e;

    localparam logic [7:0] WORD_BITS = 8'd128;

    // The index only tags the instance; reject nonsense values at elaboration.
    if (ssm_idx < 0) begin : g_bad_idx
        $error("bitpack_ssm: ssm_idx must be non-negative");
    end

    state_e       state_q, state_d;
    logic [254:0] acc_q, acc_d;
    logic [7:0]   fill_q, fill_d;
    logic         flush_done_q, flush_done_d;

    logic [7:0]   sz;
    logic [127:0] blk_masked;
    logic [254:0] blk_placed;
    logic         accept;
    logic         emit;

    // Outputs decode purely from registered state.
    assign blk_rdy    = (state_q == ACTIVE) && (fill_q < WORD_BITS);
    assign word_vld   = (fill_q >= WORD_BITS) || ((state_q == FLUSH) && (fill_q != 8'd0));
    assign word_data  = acc_q[254:127];
    assign word_last  = (state_q == FLUSH) && (fill_q <= WORD_BITS) && word_vld;
    assign flush_done = flush_done_q;

    assign accept = blk_vld && blk_rdy;
    assign emit   = word_vld && word_rdy;

    // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch can be inferred.
    always_comb begin
        sz         = (blk_size > WORD_BITS) ? WORD_BITS : blk_size;
        blk_masked = blk_bits & ~({128{1'b1}} >> sz);
        blk_placed = {blk_masked, 127'b0} >> fill_q;

        acc_d  = acc_q;
        fill_d = fill_q;
        if (accept) begin
            acc_d  = acc_q | blk_placed;
            fill_d = fill_q + sz;
        end else if (emit) begin
            acc_d  = {acc_q[126:0], 128'b0};
            fill_d = (fill_q >= WORD_BITS) ? (fill_q - WORD_BITS) : 8'd0;
        end

        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fill_d == 8'd0) begin
                    state_d      = ACTIVE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

`ifdef BITPACK_SSM_STATS_EN
    logic [31:0] bit_count_q, bit_count_d;

    // The count restarts once a completed flush has been reported.
    always_comb begin
        bit_count_d = flush_done_q ? 32'd0 : bit_count_q;
        if (accept) begin
            bit_count_d = bit_count_d + {24'd0, sz};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_count_q <= 32'd0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;
`endif

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACTIVE;
            acc_q        <= '0;
            fill_q       <= 8'd0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule
